mgt_01_fp_sqrt_arbiter: RTL and testbench

//  Shares one iterative FP square-root unit between NUM_REQ requesters (issue slots).

---
 rtl/mgt_01_fp_sqrt_arbiter_pkg.sv | 27 ++
 rtl/mgt_01_fp_sqrt_arbiter_rr.sv | 37 +++
 rtl/mgt_01_fp_sqrt_arbiter.sv | 152 +++++++++++++++
 tb/tb_mgt_01_fp_sqrt_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mgt_01_fp_sqrt_arbiter_pkg.sv
// Shared types for the MGT-01 FP square-root arbiter: arbiter states, the IEEE-754
// single-precision view of operands and the canonical quiet NaN.
package mgt_01_fp_sqrt_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } sqrt_arb_state_e;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float_t;

    // Internal states of the iterative unit, kept here so both sides share one definition.
    typedef enum logic [1:0] {
        FU_IDLE = 2'd0,
        FU_BUSY = 2'd1,
        FU_DONE = 2'd2
    } fu_state_e;

    localparam float_t CANO_NAN = 32'h7FC0_0000;

endpackage

// File: rtl/mgt_01_fp_sqrt_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping,
// returned as a one-hot grant plus its index.
module mgt_01_rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] id_o
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   rot;
    logic [IDW:0]   sum;

    // Scanning downwards lets the nearest request after the pointer be written last.
    always_comb begin
        req_dbl = {req_i, req_i};
        rot     = req_dbl[ptr_i +: N];
        gnt_o   = '0;
        id_o    = '0;
        sum     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = {1'b0, ptr_i} + (IDW+1)'(i);
                if (sum >= (IDW+1)'(N)) begin
                    sum = sum - (IDW+1)'(N);
                end
                id_o              = sum[IDW-1:0];
                gnt_o             = '0;
                gnt_o[sum[IDW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mgt_01_fp_sqrt_arbiter.sv
// Shares one iterative FP square-root unit between NUM_REQ issue slots: round-robin
// grant, restart and clock the unit, return the tagged result, abort on watchdog expiry.
module mgt_01_fp_sqrt_arbiter
    import mgt_01_fp_sqrt_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ*32-1:0] radicand_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [ID_W-1:0]       res_id_o,
    output logic [31:0]           res_root_o,
    output logic                  res_invalid_o,
    output logic                  res_overflow_o,
    output logic                  res_underflow_o,
    output logic                  res_timeout_o,
    output logic [31:0]           sqrt_radicand_o,
    output logic                  sqrt_clk_en_o,
    output logic                  sqrt_rst_n_o,
    input  logic [31:0]           sqrt_root_i,
    input  logic                  sqrt_valid_i,
    input  logic                  sqrt_invalid_op_i,
    input  logic                  sqrt_overflow_i,
    input  logic                  sqrt_underflow_i
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    sqrt_arb_state_e      state_q;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      id_q;
    float_t               radicand_q;
    float_t               root_q;
    logic                 res_valid_q, invalid_q, overflow_q, underflow_q, timeout_q;
    logic                 clk_en_q, unit_rst_n_q;
    logic [WD_W-1:0]      wdog_q;
    logic [NUM_REQ-1:0]   arb_gnt;
    logic [ID_W-1:0]      arb_id;
    logic [31:0]          sel_rad;

    mgt_01_rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_rr (
        .req_i (req_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .id_o  (arb_id)
    );

    always_comb begin
        sel_rad = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_gnt[k]) begin
                sel_rad = radicand_i[32*k +: 32];
            end
        end
    end

    assign rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);

    // Grant is combinational so the requester's radicand is captured in the grant cycle.
    assign gnt_o = (state_q == S_IDLE && !rst_i) ? arb_gnt : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            radicand_q   <= '0;
            root_q       <= '0;
            res_valid_q  <= 1'b0;
            invalid_q    <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            timeout_q    <= 1'b0;
            clk_en_q     <= 1'b0;
            unit_rst_n_q <= 1'b0;
            wdog_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|req_i) begin
                        id_q         <= arb_id;
                        radicand_q   <= sel_rad;
                        unit_rst_n_q <= 1'b0;
                        clk_en_q     <= 1'b1;
                        wdog_q       <= '0;
                        state_q      <= S_ISSUE;
                    end else begin
                        clk_en_q <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    unit_rst_n_q <= 1'b1;
                    clk_en_q     <= 1'b1;
                    wdog_q       <= '0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    if (sqrt_valid_i) begin
                        root_q      <= sqrt_root_i;
                        invalid_q   <= sqrt_invalid_op_i;
                        overflow_q  <= sqrt_overflow_i;
                        underflow_q <= sqrt_underflow_i;
                        timeout_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        clk_en_q    <= 1'b0;
                        state_q     <= S_DONE;
                    end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        root_q      <= CANO_NAN;
                        invalid_q   <= 1'b0;
                        overflow_q  <= 1'b0;
                        underflow_q <= 1'b0;
                        timeout_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        clk_en_q    <= 1'b0;
                        state_q     <= S_DONE;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
                S_DONE: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign res_valid_o     = res_valid_q;
    assign res_id_o        = id_q;
    assign res_root_o      = root_q;
    assign res_invalid_o   = invalid_q;
    assign res_overflow_o  = overflow_q;
    assign res_underflow_o = underflow_q;
    assign res_timeout_o   = timeout_q;
    assign sqrt_radicand_o = radicand_q;
    assign sqrt_clk_en_o   = clk_en_q;
    assign sqrt_rst_n_o    = unit_rst_n_q;

endmodule

// File: tb/tb_mgt_01_fp_sqrt_arbiter.sv
// Directed bench for mgt_01_fp_sqrt_arbiter with a behavioural sqrt-unit stub that
// answers a fixed table of radicands after a fixed number of enabled cycles.
module tb_mgt_01_fp_sqrt_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int TIMEOUT  = 40;
    localparam int STUB_LAT = 28;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [127:0] radicand;
    logic [3:0]  gnt;
    logic        res_valid, res_ready;
    logic [1:0]  res_id;
    logic [31:0] res_root;
    logic        res_invalid, res_overflow, res_underflow, res_timeout;
    logic [31:0] sqrt_radicand;
    logic        sqrt_clk_en, sqrt_rst_n;
    logic [31:0] sqrt_root;
    logic        sqrt_valid = 1'b0;
    logic        sqrt_inv, sqrt_ovf, sqrt_unf;

    logic [5:0]  stub_cnt = '0;
    logic        stub_hang = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_wait;

    always #5 clk = ~clk;

    mgt_01_fp_sqrt_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .ID_W           (2),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_i             (req),
        .radicand_i        (radicand),
        .gnt_o             (gnt),
        .res_valid_o       (res_valid),
        .res_ready_i       (res_ready),
        .res_id_o          (res_id),
        .res_root_o        (res_root),
        .res_invalid_o     (res_invalid),
        .res_overflow_o    (res_overflow),
        .res_underflow_o   (res_underflow),
        .res_timeout_o     (res_timeout),
        .sqrt_radicand_o   (sqrt_radicand),
        .sqrt_clk_en_o     (sqrt_clk_en),
        .sqrt_rst_n_o      (sqrt_rst_n),
        .sqrt_root_i       (sqrt_root),
        .sqrt_valid_i      (sqrt_valid),
        .sqrt_invalid_op_i (sqrt_inv),
        .sqrt_overflow_i   (sqrt_ovf),
        .sqrt_underflow_i  (sqrt_unf)
    );

    // Unit stub: restarts on its reset, counts enabled cycles, then holds valid.
    always @(posedge clk) begin
        if (!sqrt_rst_n) begin
            stub_cnt   <= '0;
            sqrt_valid <= 1'b0;
        end else if (sqrt_clk_en && !stub_hang && !sqrt_valid) begin
            stub_cnt <= stub_cnt + 6'd1;
            if (stub_cnt == 6'(STUB_LAT - 1)) sqrt_valid <= 1'b1;
        end
    end

    always_comb begin
        sqrt_root = 32'h0;
        sqrt_inv  = 1'b0;
        sqrt_ovf  = 1'b0;
        sqrt_unf  = 1'b0;
        if (stub_hang) begin
            sqrt_root = 32'h1234_5678;
            sqrt_inv  = 1'b1;
            sqrt_ovf  = 1'b1;
            sqrt_unf  = 1'b1;
        end else begin
            case (sqrt_radicand)
                32'h40DC_8B44: sqrt_root = 32'h4028_044A;
                32'h4080_0000: sqrt_root = 32'h4000_0000;
                32'h4110_0000: sqrt_root = 32'h4040_0000;
                32'h4180_0000: sqrt_root = 32'h4080_0000;
                32'h3F80_0000: sqrt_root = 32'h3F80_0000;
                32'hC000_0000: begin sqrt_root = 32'h7FC0_0000; sqrt_inv = 1'b1; end
                32'h7F80_0000: begin sqrt_root = 32'h7F80_0000; sqrt_ovf = 1'b1; end
                32'h0000_0001: begin sqrt_root = 32'h1A35_04F3; sqrt_unf = 1'b1; end
                default:       sqrt_root = 32'h0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'h0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'h0);
        chk({tag, "_res_id"}, 32'(res_id), 32'h0);
        chk({tag, "_res_root"}, res_root, 32'h0);
        chk({tag, "_flags"}, {28'h0, res_invalid, res_overflow, res_underflow, res_timeout}, 32'h0);
        chk({tag, "_sqrt_radicand"}, sqrt_radicand, 32'h0);
        chk({tag, "_sqrt_clk_en"}, 32'(sqrt_clk_en), 32'h0);
        chk({tag, "_sqrt_rst_n"}, 32'(sqrt_rst_n), 32'h0);
    endtask

    task automatic issue(input logic [3:0] r, input logic [3:0] exp_g,
                         input logic [31:0] exp_rad, input bit hold);
        req = r;
        #1;
        chk("gnt", 32'(gnt), 32'(exp_g));
        @(negedge clk);
        if (!hold) req = '0;
        chk("issue_clk_en", 32'(sqrt_clk_en), 32'h1);
        chk("issue_rst_n", 32'(sqrt_rst_n), 32'h0);
        chk("issue_radicand", sqrt_radicand, exp_rad);
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("res_valid_wait", 32'(res_valid), 32'h1);
    endtask

    task automatic chk_res(input string tag, input logic [1:0] id, input logic [31:0] root,
                           input logic inv, input logic ovf, input logic unf, input logic to);
        chk({tag, "_id"}, 32'(res_id), 32'(id));
        chk({tag, "_root"}, res_root, root);
        chk({tag, "_flags"}, {28'h0, res_invalid, res_overflow, res_underflow, res_timeout},
            {28'h0, inv, ovf, unf, to});
        chk({tag, "_done_clk_en"}, 32'(sqrt_clk_en), 32'h0);
    endtask

    task automatic accept();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("accept_valid_low", 32'(res_valid), 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req       = 4'b1111;
        res_ready = 1'b0;
        radicand  = {32'h0, 32'h0, 32'h0, 32'h40DC_8B44};

        // Reset state, with requests pending to show no grant leaks through reset.
        @(negedge clk);
        @(negedge clk);
        chk_reset("reset");
        req = '0;
        rst = 1'b0;
        @(negedge clk);

        // Single request on slot 0.
        issue(4'b0001, 4'b0001, 32'h40DC_8B44, 1'b0);
        wait_res(n_wait);
        chk_res("single", 2'd0, 32'h4028_044A, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("done_rst_n", 32'(sqrt_rst_n), 32'h1);
        accept();

        // All four held from pointer 0: ids 0,1,2,3 then wrap to 0.
        do_reset();
        radicand = {32'h3F80_0000, 32'h4180_0000, 32'h4110_0000, 32'h4080_0000};
        issue(4'b1111, 4'b0001, 32'h4080_0000, 1'b1);
        wait_res(n_wait);
        chk_res("rr0", 2'd0, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        accept();
        issue(4'b1111, 4'b0010, 32'h4110_0000, 1'b1);
        wait_res(n_wait);
        chk_res("rr1", 2'd1, 32'h4040_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        accept();
        issue(4'b1111, 4'b0100, 32'h4180_0000, 1'b1);
        wait_res(n_wait);
        chk_res("rr2", 2'd2, 32'h4080_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        accept();
        issue(4'b1111, 4'b1000, 32'h3F80_0000, 1'b1);
        wait_res(n_wait);
        chk_res("rr3", 2'd3, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        accept();
        issue(4'b1111, 4'b0001, 32'h4080_0000, 1'b0);
        wait_res(n_wait);
        chk_res("rr_wrap", 2'd0, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        accept();

        // Negative radicand on slot 2; result held 10 cycles with other requests pending.
        radicand[95:64] = 32'hC000_0000;
        issue(4'b0100, 4'b0100, 32'hC000_0000, 1'b0);
        wait_res(n_wait);
        chk_res("neg", 2'd2, 32'h7FC0_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        req = 4'b1011;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold_gnt", 32'(gnt), 32'h0);
            chk("hold_valid", 32'(res_valid), 32'h1);
            chk("hold_root", res_root, 32'h7FC0_0000);
        end
        accept();
        // Pointer is now 3: slot 3 wins over 0 and 1.
        issue(4'b1011, 4'b1000, 32'h3F80_0000, 1'b0);
        wait_res(n_wait);
        chk_res("after_hold", 2'd3, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        accept();

        // Flag routing: overflow on slot 1, underflow on slot 0.
        radicand[63:32] = 32'h7F80_0000;
        radicand[31:0]  = 32'h0000_0001;
        issue(4'b0010, 4'b0010, 32'h7F80_0000, 1'b0);
        wait_res(n_wait);
        chk_res("ovf", 2'd1, 32'h7F80_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        accept();
        issue(4'b0001, 4'b0001, 32'h0000_0001, 1'b0);
        wait_res(n_wait);
        chk_res("unf", 2'd0, 32'h1A35_04F3, 1'b0, 1'b0, 1'b1, 1'b0);
        accept();

        // Hung unit: ISSUE is 1 cycle, then TIMEOUT WAIT cycles, then DONE.
        stub_hang = 1'b1;
        issue(4'b1000, 4'b1000, 32'h3F80_0000, 1'b0);
        wait_res(n_wait);
        chk("timeout_cycles", 32'(n_wait), 32'(TIMEOUT + 1));
        chk_res("timeout", 2'd3, 32'h7FC0_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        accept();
        stub_hang = 1'b0;

        // Reset pulse mid-WAIT abandons the op; a fresh grant then completes.
        radicand[95:64] = 32'h4110_0000;
        issue(4'b0100, 4'b0100, 32'h4110_0000, 1'b0);
        repeat (10) @(negedge clk);
        chk("wait_clk_en", 32'(sqrt_clk_en), 32'h1);
        chk("wait_rst_n", 32'(sqrt_rst_n), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("midwait_reset");
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("no_result_after_reset", 32'(res_valid), 32'h0);
        end
        issue(4'b1000, 4'b1000, 32'h3F80_0000, 1'b0);
        wait_res(n_wait);
        chk_res("regrant", 2'd3, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        accept();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
